// File: rtl/score_pkg.sv
// Shared constants and state encoding for the score RAM and its leader scanner.
package score_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned MAX_SLOT = 15;

    localparam logic [ADDR_W-1:0] MaxSlotAddr = ADDR_W'(MAX_SLOT);
    localparam logic [ADDR_W-1:0] LastScanIdx = ADDR_W'(MAX_SLOT - 1);
    localparam logic [ADDR_W-1:0] LastClrIdx  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        StClear,
        StRun
    } state_e;

endpackage

// File: rtl/score_leader_scan.sv
// Background scanner: walks slots 0..MAX_SLOT-1 one per cycle and publishes the
// highest score (lowest id on ties) at the end of each pass.
module score_leader_scan
    import score_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] best_id_o,
    output logic [DATA_W-1:0] best_score_o
);

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] run_id_q, run_id_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [ADDR_W-1:0] best_id_q, best_id_d;
    logic [DATA_W-1:0] best_score_q, best_score_d;
    logic [ADDR_W-1:0] id_nxt;
    logic [DATA_W-1:0] max_nxt;

    // Fold the current slot into the running max and advance the index.
    always_comb begin
        idx_d        = idx_q;
        run_id_d     = run_id_q;
        run_max_d    = run_max_q;
        best_id_d    = best_id_q;
        best_score_d = best_score_q;

        // Slot 0 seeds the pass; afterwards only a strictly larger score wins.
        if (idx_q == '0) begin
            max_nxt = rd_data_i;
            id_nxt  = '0;
        end else if (rd_data_i > run_max_q) begin
            max_nxt = rd_data_i;
            id_nxt  = idx_q;
        end else begin
            max_nxt = run_max_q;
            id_nxt  = run_id_q;
        end

        if (run_i) begin
            run_max_d = max_nxt;
            run_id_d  = id_nxt;
            if (idx_q == LastScanIdx) begin
                idx_d        = '0;
                best_id_d    = id_nxt;
                best_score_d = max_nxt;
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end
    end

    // Scanner state and published leader registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q        <= '0;
            run_id_q     <= '0;
            run_max_q    <= '0;
            best_id_q    <= '0;
            best_score_q <= '0;
        end else begin
            idx_q        <= idx_d;
            run_id_q     <= run_id_d;
            run_max_q    <= run_max_d;
            best_id_q    <= best_id_d;
            best_score_q <= best_score_d;
        end
    end

    assign rd_addr_o    = idx_q;
    assign best_id_o    = best_id_q;
    assign best_score_o = best_score_q;

endmodule

// File: rtl/score_memory.sv
// 16x4 score RAM with post-reset self-clear, registered read port, stored-max
// mirror of the top slot and a background leader scanner.
// Build option: define SCORE_MEM_BYPASS_EN for write-first read-during-write;
// otherwise the read port is read-first like an inferred block RAM.
module score_memory
    import score_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              wren_i,
    output logic [DATA_W-1:0] q_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] best_id_o,
    output logic [DATA_W-1:0] best_score_o,
    output logic [DATA_W-1:0] stored_max_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] stored_max_q, stored_max_d;
    logic              run;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;

    assign run = (state_q == StRun);

    // Clear sequencer: one slot per cycle, then hand over to normal operation.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LastClrIdx) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array writes: zeroing during clear, controller writes only once running.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == StClear) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wren_i) begin
                mem_q[address_i] <= data_i;
            end
        end
    end

    // Read-port and stored-max next values; both held at zero while clearing.
    always_comb begin
        q_d          = '0;
        stored_max_d = '0;
        if (run) begin
`ifdef SCORE_MEM_BYPASS_EN
            q_d = wren_i ? data_i : mem_q[address_i];
`else
            q_d = mem_q[address_i];
`endif
            // Mirror reflects the write landing on this same edge.
            stored_max_d = (wren_i && (address_i == MaxSlotAddr)) ? data_i : mem_q[MaxSlotAddr];
        end
    end

    // Output registers for the controller and display paths.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q          <= '0;
            stored_max_q <= '0;
        end else begin
            q_q          <= q_d;
            stored_max_q <= stored_max_d;
        end
    end

    // Combinational second read port feeding the scanner.
    assign scan_data = mem_q[scan_addr];

    score_leader_scan u_scan (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .run_i        (run),
        .rd_data_i    (scan_data),
        .rd_addr_o    (scan_addr),
        .best_id_o    (best_id_o),
        .best_score_o (best_score_o)
    );

    assign q_o          = q_q;
    assign busy_o       = ~run;
    assign stored_max_o = stored_max_q;

endmodule

// File: tb/tb_score_memory.sv
// Self-checking bench for score_memory: directed scenarios plus random traffic
// compared against an array model of the RAM and a max-search leader model.
module tb_score_memory;
    import score_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q;
    logic              busy;
    logic [ADDR_W-1:0] best_id;
    logic [DATA_W-1:0] best_score;
    logic [DATA_W-1:0] stored_max;

    int checks   = 0;
    int failures = 0;

    int model_mem [DEPTH];

    always #5 clk = ~clk;

    score_memory dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .address_i    (address),
        .data_i       (data),
        .wren_i       (wren),
        .q_o          (q),
        .busy_o       (busy),
        .best_id_o    (best_id),
        .best_score_o (best_score),
        .stored_max_o (stored_max)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One RUN-state port cycle, checked against the array model.
    task automatic do_cycle(input int a, input int d, input bit we);
        int exp_q;
        address = a[ADDR_W-1:0];
        data    = d[DATA_W-1:0];
        wren    = we;
        step();
`ifdef SCORE_MEM_BYPASS_EN
        exp_q = we ? d : model_mem[a];
`else
        exp_q = model_mem[a];
`endif
        if (we) model_mem[a] = d;
        chk("q", {28'd0, q}, exp_q);
        chk("stored_max", {28'd0, stored_max}, model_mem[MAX_SLOT]);
        wren = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle($urandom_range(0, DEPTH - 1), 0, 1'b0);
    endtask

    // Leader = highest score in slots 0..MAX_SLOT-1, lowest id on ties.
    task automatic check_leader(input string tag);
        int bid = 0;
        int bs  = model_mem[0];
        for (int i = 1; i < MAX_SLOT; i++) begin
            if (model_mem[i] > bs) begin
                bs  = model_mem[i];
                bid = i;
            end
        end
        chk({tag, "_best_id"}, {28'd0, best_id}, bid);
        chk({tag, "_best_score"}, {28'd0, best_score}, bs);
    endtask

    // Hold reset, check reset values, then time the clear with writes attempted.
    task automatic apply_reset(input int n);
        int cnt = 0;
        reset = 1'b1;
        wren  = 1'b0;
        repeat (n) step();
        chk("rst_q", {28'd0, q}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_best_id", {28'd0, best_id}, 0);
        chk("rst_best_score", {28'd0, best_score}, 0);
        chk("rst_stored_max", {28'd0, stored_max}, 0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        reset   = 1'b0;
        address = 4'd5;
        data    = 4'd15;
        wren    = 1'b1;
        while (busy === 1'b1 && cnt < 40) begin
            chk("clear_q", {28'd0, q}, 0);
            cnt++;
            step();
        end
        wren = 1'b0;
        chk("busy_cycles", cnt, 16);
    endtask

    initial begin
        reset   = 1'b1;
        address = '0;
        data    = '0;
        wren    = 1'b0;

        apply_reset(3);

        // Every slot reads back zero, including slot 5 written during clear.
        for (int a = 0; a < DEPTH; a++) do_cycle(a, 0, 1'b0);
        idle(32);
        check_leader("post_clear");

        // Write then read the next cycle.
        do_cycle(3, 7, 1'b1);
        do_cycle(3, 0, 1'b0);
        chk("wr_rd_addr3", {28'd0, q}, 7);

        // Tie on 5 between slots 2 and 9 goes to the lower id.
        do_cycle(3, 0, 1'b1);
        do_cycle(2, 5, 1'b1);
        do_cycle(9, 5, 1'b1);
        idle(32);
        check_leader("tie");
        chk("tie_id_const", {28'd0, best_id}, 2);

        // Slot 15 feeds stored_max but not the leader.
        do_cycle(15, 12, 1'b1);
        chk("smax_12", {28'd0, stored_max}, 12);
        idle(32);
        check_leader("slot15_excluded");

        // Read-during-write on slot 4.
        do_cycle(4, 1, 1'b1);
        do_cycle(4, 9, 1'b1);
`ifdef SCORE_MEM_BYPASS_EN
        chk("rdw_addr4", {28'd0, q}, 9);
`else
        chk("rdw_addr4", {28'd0, q}, 1);
`endif
        do_cycle(4, 0, 1'b0);
        idle(32);
        check_leader("after_rdw");

        // Random traffic with settled-leader checks between bursts.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 40; k++) begin
                do_cycle($urandom_range(0, DEPTH - 1), $urandom_range(0, 15),
                         1'($urandom_range(0, 1)));
            end
            idle(32);
            check_leader("random");
        end

        // Reset in the middle of a scan after fresh writes.
        do_cycle(3, 11, 1'b1);
        do_cycle(7, 14, 1'b1);
        idle(7);
        apply_reset(1);
        do_cycle(3, 0, 1'b0);
        chk("post_reset_addr3", {28'd0, q}, 0);
        for (int a = 0; a < DEPTH; a++) do_cycle(a, 0, 1'b0);
        idle(32);
        check_leader("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_memory.md
# score_memory

Responder side of the score-RAM port driven by `score_controller`: a 16-entry x 4-bit synchronous memory that accepts `address`/`data`/`wren` and returns `q` one clock later. The block clears itself after reset, holding the all-time maximum in slot 15 and per-player scores in slots 0-14. A background scanner continuously walks slots 0-14 and publishes the current leader (id and score) for the display path.

## Interface
- `ADDR_W`, 4: address width; depth is 2**ADDR_W.
- `DATA_W`, 4: score width.
- `MAX_SLOT`, 15: slot reserved for the stored maximum; it is excluded from the leader scan.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in ADDR_W: read/write address from the controller.
- `data` in DATA_W: write data.
- `wren` in 1: write enable, sampled each edge.
- `q` out DATA_W: registered read data.
- `busy` out 1: high while the post-reset clear is running.
- `best_id` out ADDR_W: slot index of the current leader.
- `best_score` out DATA_W: score of the current leader.
- `stored_max` out DATA_W: registered copy of mem[MAX_SLOT].

## Operation
- States are CLEAR and RUN.
- Reset: state=CLEAR, clear counter=0.
- Reset values: `q`=0, `busy`=1, `best_id`=0, `best_score`=0, `stored_max`=0.
- CLEAR state:
  - Writes 0 to mem[counter] each cycle for 16 cycles, with counter 0..15.
  - Controller writes are ignored and `q` is held at 0.
  - When counter=15, the next state is RUN and `busy` falls.
- RUN state, port behaviour:
  - Each edge, `q` <= mem[address].
  - If `wren`=1, mem[address] <= data.
  - Read-during-write to the same address is governed by Configuration.
- RUN state, scanner:
  - Index i steps 0..MAX_SLOT-1, one slot per cycle.
  - At i=0 the running max is seeded with mem[0] and the running id with 0.
  - Otherwise the running values update only when mem[i] > running max (strict), so ties go to the lowest id.
  - At i=MAX_SLOT-1, `best_id` and `best_score` take the final running values and i wraps to 0.
  - A full scan therefore takes 15 cycles.
- `stored_max` updates every RUN cycle from mem[MAX_SLOT], post-write.
- Arithmetic is compare-only and unsigned; the block performs no addition, so no overflow is possible.
- A reset asserted mid-scan or mid-clear restarts CLEAR. Scanner state and all outputs return to their reset values, and the memory contents are re-zeroed.

## Timing
- Read latency is 1: an address presented before edge N gives `q` valid after edge N. This satisfies the controller's one-WAIT-cycle read sequence.
- A write presented before edge N is visible to a read addressed before edge N+1, with `q` valid after N+1.
- A leader change is reflected in `best_*` at most 30 cycles after the write (worst case: the write lands just after that slot was scanned).
- `stored_max` follows a write to MAX_SLOT after 1 cycle.
- `busy` is high for exactly 16 cycles after reset deasserts. The first accepted write occurs on the 17th edge.

## Configuration
- `SCORE_MEM_BYPASS_EN` defined: on a read-during-write to the same address, `q` returns the new `data` (write-first).
- `SCORE_MEM_BYPASS_EN` undefined: `q` returns the old contents (read-first, matching an inferred block RAM).
- The scanner always sees post-write contents in both modes.

## Structure
- Shared package `score_pkg` holds:
  - `ADDR_W`, `DATA_W`, `MAX_SLOT` constants
  - state enum {CLEAR, RUN}
- One sub-module, `score_leader_scan`. It holds the index counter, running max/id and output registers. It reads through a combinational second port of the array and takes a `run` enable from the parent.
- The array and the CLEAR FSM stay in `score_memory`.

## Test plan
- Reset, then wait: `busy`=1 for 16 cycles. Afterwards, reads of every address return 0, and `best_id`=0, `best_score`=0.
- Write 7 to addr 3, then read addr 3 the next cycle: `q`=7 one edge after the address.
- Write 5 to addr 2 and 5 to addr 9, others 0: after 30 cycles, `best_id`=2 and `best_score`=5 (tie resolves to the lower id).
- Write 12 to addr 15: `stored_max`=12 one cycle later, and `best_*` are unaffected (slot 15 is excluded from the scan).
- Address 4 holds 1; write 9 with read of the same address in one cycle: `q`=9 with `SCORE_MEM_BYPASS_EN`, `q`=1 without it.
- Assert reset mid-scan after several writes: `busy` rises, all outputs return to 0, and after the clear addr 3 reads 0.
